// File: rtl/izh_step_sequencer.sv
// Time-step sequencer for one Izhikevich neuron core: issues per-neuron state into the
// 4-stage pipeline, writes results back and queues fired neuron indices on a spike FIFO.
// Optional build macro IZH_SEQ_CLR_I_EN: writeback also clears the neuron's input current.
module izh_step_sequencer #(
    parameter int N_NEURONS = 16,
    parameter int IDX_W     = 4,
    parameter int PIPE_LAT  = 4,
    parameter int SPK_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_start,
    output logic             step_busy,
    output logic             step_done,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [16:0]      cfg_v,
    input  logic [16:0]      cfg_u,
    input  logic [16:0]      cfg_i,
    output logic [16:0]      nrn_v,
    output logic [16:0]      nrn_u,
    output logic [16:0]      nrn_i,
    input  logic [16:0]      v_prime,
    input  logic [16:0]      u_prime,
    input  logic             fired,
    output logic             spk_valid,
    input  logic             spk_ready,
    output logic [IDX_W-1:0] spk_idx,
    output logic             spk_overflow
);

    localparam int PW = (SPK_DEPTH > 1) ? $clog2(SPK_DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_issue_idx;
    tag_t             r_tag [PIPE_LAT];
    logic [16:0]      r_mem_v [N_NEURONS];
    logic [16:0]      r_mem_u [N_NEURONS];
    logic [16:0]      r_mem_i [N_NEURONS];
    logic [IDX_W-1:0] r_fifo [SPK_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             r_overflow;

    tag_t w_tail;
    logic w_start;
    logic w_cfg_wr;
    logic w_wb;
    logic w_full;
    logic w_pop;
    logic w_push_req;
    logic w_push;

    assign w_tail     = r_tag[PIPE_LAT-1];
    assign w_start    = (r_state == S_IDLE) && step_start;
    assign w_cfg_wr   = (r_state == S_IDLE) && cfg_we && (int'(cfg_addr) < N_NEURONS);
    assign w_wb       = w_tail.vld;
    assign w_full     = (r_count == (PW+1)'(SPK_DEPTH));
    assign w_pop      = spk_valid && spk_ready;
    assign w_push_req = w_wb && fired;
    assign w_push     = w_push_req && (!w_full || w_pop);

    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would
    // make the result depend on process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_ISSUE;
            S_ISSUE: if (r_issue_idx == LAST_IDX) w_next = S_DRAIN;
            S_DRAIN: if (w_wb && (w_tail.idx == LAST_IDX)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        step_busy = (r_state != S_IDLE);
        step_done = (r_state == S_DONE);
        nrn_v     = '0;
        nrn_u     = '0;
        nrn_i     = '0;
        if (r_state == S_ISSUE) begin
            nrn_v = r_mem_v[r_issue_idx];
            nrn_u = r_mem_u[r_issue_idx];
            nrn_i = r_mem_i[r_issue_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_idx <= '0;
        end else if (w_start) begin
            r_issue_idx <= '0;
        end else if (r_state == S_ISSUE) begin
            r_issue_idx <= r_issue_idx + IDX_W'(1);
        end
    end

    // Tag shift register mirrors the pipeline so the tail names the neuron whose result is at the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPE_LAT; k++) r_tag[k] <= '0;
        end else begin
            r_tag[0] <= '{vld: (r_state == S_ISSUE), idx: r_issue_idx};
            for (int k = 1; k < PIPE_LAT; k++) r_tag[k] <= r_tag[k-1];
        end
    end

    // NOTE: the state memory is reset explicitly because all neuron words must read 0 after rst,
    // so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                r_mem_v[k] <= '0;
                r_mem_u[k] <= '0;
                r_mem_i[k] <= '0;
            end
        end else begin
            if (w_cfg_wr) begin
                r_mem_v[cfg_addr] <= cfg_v;
                r_mem_u[cfg_addr] <= cfg_u;
                r_mem_i[cfg_addr] <= cfg_i;
            end
            if (w_wb) begin
                r_mem_v[w_tail.idx] <= v_prime;
                r_mem_u[w_tail.idx] <= u_prime;
`ifdef IZH_SEQ_CLR_I_EN
                r_mem_i[w_tail.idx] <= '0;
`endif
            end
        end
    end

    // Spike FIFO survives step_start so the router can drain it across steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SPK_DEPTH; k++) r_fifo[k] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_tail.idx;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_start) r_overflow <= 1'b0;
            if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign spk_valid    = (r_count != '0);
    assign spk_idx      = r_fifo[r_rd_ptr];
    assign spk_overflow = r_overflow;

endmodule

// File: tb/tb_izh_step_sequencer.sv
// Directed bench for izh_step_sequencer with a 4-cycle pipeline model (v' = v+1, u' = u, fired = u[0]).
// A small scoreboard of neuron words predicts what each step issues.
module tb_izh_step_sequencer;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int PL = 4;
    localparam int SD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          step_start;
    logic          step_busy;
    logic          step_done;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [16:0]   cfg_v, cfg_u, cfg_i;
    logic [16:0]   nrn_v, nrn_u, nrn_i;
    logic [16:0]   v_prime, u_prime;
    logic          fired;
    logic          spk_valid;
    logic          spk_ready;
    logic [IW-1:0] spk_idx;
    logic          spk_overflow;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    bit seen_valid;
    int spk_log[$];

    logic [16:0] exp_v [N];
    logic [16:0] exp_u [N];
    logic [16:0] exp_i [N];
    logic [16:0] obs_v [N];
    logic [16:0] obs_u [N];
    logic [16:0] obs_i [N];

    logic [16:0] pv [PL];
    logic [16:0] pu [PL];
    logic        pf [PL];

    izh_step_sequencer #(
        .N_NEURONS(N), .IDX_W(IW), .PIPE_LAT(PL), .SPK_DEPTH(SD)
    ) dut (
        .clk(clk), .rst(rst),
        .step_start(step_start), .step_busy(step_busy), .step_done(step_done),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_v(cfg_v), .cfg_u(cfg_u), .cfg_i(cfg_i),
        .nrn_v(nrn_v), .nrn_u(nrn_u), .nrn_i(nrn_i),
        .v_prime(v_prime), .u_prime(u_prime), .fired(fired),
        .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx),
        .spk_overflow(spk_overflow)
    );

    always #5 clk = ~clk;

    // Pipeline model: samples at the same edge as the tag enters, result PL cycles later.
    always @(posedge clk) begin
        pv[0] <= nrn_v + 17'd1;
        pu[0] <= nrn_u;
        pf[0] <= nrn_u[0];
        for (int k = 1; k < PL; k++) begin
            pv[k] <= pv[k-1];
            pu[k] <= pu[k-1];
            pf[k] <= pf[k-1];
        end
    end
    assign v_prime = pv[PL-1];
    assign u_prime = pu[PL-1];
    assign fired   = pf[PL-1];

    always @(negedge clk) begin
        if (!rst) begin
            if (spk_valid) seen_valid = 1'b1;
            if (spk_valid && spk_ready) spk_log.push_back(int'(spk_idx));
            if (step_done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input int a, input logic [16:0] v, input logic [16:0] u,
                             input logic [16:0] i);
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_addr = IW'(a);
        cfg_v    = v;
        cfg_u    = u;
        cfg_i    = i;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        exp_v[a] = v;
        exp_u[a] = u;
        exp_i[a] = i;
    endtask

    // One step; optionally pokes step_start/cfg_we during ISSUE. Checks issued words and timing.
    task automatic run_step(input bit disturb);
        int n;
        int d0;
        d0 = done_cnt;
        @(posedge clk); #1 step_start = 1'b1;
        @(posedge clk); #1 step_start = 1'b0;
        n = 0;
        check("busy_at_start", step_busy, 1);
        check("ovf_cleared_by_start", spk_overflow, 0);
        obs_v[0] = nrn_v; obs_u[0] = nrn_u; obs_i[0] = nrn_i;
        while (!step_done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n < N) begin
                obs_v[n] = nrn_v; obs_u[n] = nrn_u; obs_i[n] = nrn_i;
            end
            if (disturb && n == 1) begin
                step_start = 1'b1;
                cfg_we     = 1'b1;
                cfg_addr   = '0;
                cfg_v      = 17'h07777;
                cfg_u      = 17'h07777;
                cfg_i      = 17'h07777;
            end
            if (disturb && n == 2) begin
                step_start = 1'b0;
                cfg_we     = 1'b0;
            end
        end
        check("step_latency", n, N + PL);
        @(posedge clk); #1;
        check("done_one_cycle", step_done, 0);
        check("idle_after_done", step_busy, 0);
        check("done_pulse_count", done_cnt - d0, 1);
        for (int k = 0; k < N; k++) begin
            check($sformatf("issue_v[%0d]", k), obs_v[k], exp_v[k]);
            check($sformatf("issue_u[%0d]", k), obs_u[k], exp_u[k]);
            check($sformatf("issue_i[%0d]", k), obs_i[k], exp_i[k]);
            exp_v[k] = exp_v[k] + 17'd1;
`ifdef IZH_SEQ_CLR_I_EN
            exp_i[k] = '0;
`endif
        end
    endtask

    initial begin
        rst = 1'b1; step_start = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_v = '0; cfg_u = '0; cfg_i = '0; spk_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp_v[k] = '0; exp_u[k] = '0; exp_i[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", step_busy, 0);
        check("rst_done", step_done, 0);
        check("rst_spk_valid", spk_valid, 0);
        check("rst_overflow", spk_overflow, 0);
        check("rst_nrn_v", nrn_v, 0);
        check("rst_spk_idx", spk_idx, 0);
        rst = 1'b0;

        // Basic step, nobody fires; idx 2 carries injected current.
        for (int k = 0; k < N; k++)
            cfg_write(k, 17'h00100, 17'h00000, (k == 2) ? 17'h00500 : 17'h00000);
        seen_valid = 1'b0;
        run_step(1'b0);
        check("no_spike_valid", seen_valid, 0);

        // idx 1 and 3 fire with the consumer ready; this step also reads back v=0x0101.
        cfg_write(1, exp_v[1], 17'h00001, exp_i[1]);
        cfg_write(3, exp_v[3], 17'h00001, exp_i[3]);
        spk_ready = 1'b1;
        spk_log.delete();
        run_step(1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("spk_count_13", spk_log.size(), 2);
        if (spk_log.size() == 2) begin
            check("spk_first", spk_log[0], 1);
            check("spk_second", spk_log[1], 3);
        end
        check("ovf_after_13", spk_overflow, 0);
        check("fifo_empty_13", spk_valid, 0);

        // All fire with the consumer stalled: depth-2 FIFO keeps 0,1 and flags overflow.
        cfg_write(0, exp_v[0], 17'h00001, exp_i[0]);
        cfg_write(2, exp_v[2], 17'h00001, exp_i[2]);
        spk_ready = 1'b0;
        spk_log.delete();
        run_step(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("full_valid", spk_valid, 1);
        check("full_head", spk_idx, 0);
        check("full_overflow", spk_overflow, 1);
        spk_ready = 1'b1;
        @(posedge clk); #1;
        check("second_entry", spk_idx, 1);
        check("second_valid", spk_valid, 1);
        @(posedge clk); #1;
        check("drained", spk_valid, 0);
        check("overflow_sticky", spk_overflow, 1);
        check("drained_count", spk_log.size(), 2);
        if (spk_log.size() == 2) begin
            check("drained_first", spk_log[0], 0);
            check("drained_second", spk_log[1], 1);
        end

        // step_start and cfg_we during ISSUE are ignored; streaming push/pop never overflows.
        spk_log.delete();
        run_step(1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("stream_overflow", spk_overflow, 0);
        check("stream_count", spk_log.size(), 4);
        for (int k = 0; k < N && k < spk_log.size(); k++)
            check($sformatf("stream_idx[%0d]", k), spk_log[k], k);
        run_step(1'b0);

        // Reset in the middle of DRAIN.
        @(posedge clk); #1 step_start = 1'b1;
        @(posedge clk); #1 step_start = 1'b0;
        repeat (N + 1) begin
            @(posedge clk); #1;
        end
        check("busy_in_drain", step_busy, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", step_busy, 0);
        check("rst_mid_spk_valid", spk_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp_v[k] = '0; exp_u[k] = '0; exp_i[k] = '0;
        end
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_idle", step_busy, 0);
        spk_log.delete();
        run_step(1'b0);
        check("post_rst_no_spikes", spk_log.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
